cla_sweep_checker: RTL and testbench
====================================

# cla_sweep_checker

Exhaustive stimulus driver and response checker for the 4-bit carry-lookahead adder. It drives every `{cin, b, a}` combination onto the adder's inputs and samples the adder's `sum` and `cout` after a programmable settle time. Each response is compared against an internal reference sum, and the block reports an error count, the first failing vector and pass/fail. It is the opposite end of the adder interface, synthesizable, so it can serve as both an on-chip BIST engine and a self-checking bench component.

## Interface
- `WIDTH`, default 4: adder operand width.
- `SETTLE`, default 1: cycles between driving a vector and sampling the response. Legal values are ≥1.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep. Honoured only in IDLE or DONE.
- `a_out` out WIDTH: operand a to the adder. Registered.
- `b_out` out WIDTH: operand b to the adder. Registered.
- `cin_out` out 1: carry-in to the adder. Registered.
- `sum_in` in WIDTH: sum from the adder.
- `cout_in` in 1: carry-out from the adder.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete. Sticky until the next accepted start or reset.
- `pass` out 1: equals `done` && `err_count`==0.
- `err_count` out 2*WIDTH+2: number of mismatching vectors.
- `first_err_valid` out 1: at least one mismatch has been captured.
- `first_err_vec` out 2*WIDTH+1: index `{cin,b,a}` of the first mismatch.

## Operation
- Vector index `vec` is 2*WIDTH+1 bits, decoded as `{cin,b,a}`. It runs from 0 to 2^(2*WIDTH+1)-1 in increasing order; for WIDTH=4 that is 0..511.
- The reference result is `{cout,sum}` = a + b + cin, computed at WIDTH+1 bits with no truncation.
- The FSM has four states: IDLE, SETTLE, CHECK, DONE.
- **IDLE or DONE, `start`=1:**
  - `vec`←0, drive vector 0.
  - Clear `err_count`, `first_err_valid`, `first_err_vec` and `done`; set `busy`.
  - Clear the settle counter and go to SETTLE.
- **SETTLE:** stay until the settle counter reaches SETTLE-1, then go to CHECK. Outputs are held.
- **CHECK:**
  - Compare `{cout_in,sum_in}` with the reference for the current `vec`.
  - On mismatch, increment `err_count`. If `first_err_valid`=0, also capture `first_err_vec`←`vec` and set `first_err_valid`.
  - If `vec` is the last index, go to DONE: `busy`←0, `done`←1.
  - Otherwise `vec`←`vec`+1, drive the next vector, clear the settle counter and go to SETTLE.
- **DONE:**
  - `a_out`/`b_out`/`cin_out` hold the last vector.
  - Results hold until the next accepted `start`.
  - `start` in DONE restarts the sweep exactly as from IDLE.
- `start` in SETTLE or CHECK is ignored. It neither restarts nor alters the sweep.
- `err_count` is wide enough to hold every vector failing, so it cannot overflow and needs no saturation.
- **Reset (`rst_n`=0), any time including mid-sweep:** all outputs go to 0 and the state goes to IDLE. A partial sweep is discarded.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `cin_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_vec`=0.
- When `start` is accepted at edge t:
  - `busy`=1 and vector 0 is on the outputs after edge t.
  - The first CHECK sample is taken at edge t+SETTLE+1.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 in CHECK.
- The response is sampled at the CHECK edge, which is at least SETTLE cycles after the vector was driven.
- After the final CHECK edge:
  - `done`=1 and `busy`=0.
  - `done` rises at edge t + 2^(2W+1)·(SETTLE+1). For W=4, SETTLE=1 that is t+1024.
- `pass` is combinational from `done` and `err_count`. It has no extra latency.
- `err_count` and `first_err_*` update at the CHECK edge of the failing vector.

## Test plan
- **Correct adder model, SETTLE=1, pulse `start`:**
  - `busy` rises next edge.
  - `done` rises 1024 cycles after `start`.
  - `pass`=1, `err_count`=0, `first_err_valid`=0.
- **Adder model with `cout` stuck at 0:**
  - `err_count`=256 (120 vectors with cin=0, 136 with cin=1).
  - `first_err_vec`=0x01F (a=15, b=1, cin=0).
  - `pass`=0.
- **Adder model with `sum[0]` stuck at 0:**
  - `err_count`=256.
  - `first_err_vec`=0x001.
  - `first_err_valid`=1, `pass`=0.
- **Pulse `start` again at cycle 100 and cycle 500 of a run:**
  - Both are ignored.
  - `done` still rises at cycle 1024 with the results from the first start.
- **Deassert `rst_n` at cycle 300 of a faulty-model run:**
  - All outputs return to 0 immediately.
  - After release, a new `start` sweeps from vector 0.
  - `done` rises after a further 1024 cycles with a full, correct error count.
- **SETTLE=3, correct model:**
  - `done` rises 2048 cycles after `start`; `pass`=1.
  - Each vector is stable for exactly 4 cycles on `a_out`/`b_out`/`cin_out`.

Source files
------------

// File: rtl/cla_sweep_checker.sv
// Purpose : exhaustive sweep driver and response checker for a WIDTH-bit adder (BIST engine).
// Latency : each {cin,b,a} vector takes SETTLE+1 cycles; done rises 2^(2*WIDTH+1)*(SETTLE+1) cycles after start.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while a sweep is running.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a sweep (honoured in IDLE/DONE only)
//   a_out, b_out, cin_out : registered operands driven to the adder under test
//   sum_in, cout_in       : adder response, sampled in CHECK
//   busy, done, pass      : sweep status; pass = done && no mismatches
//   err_count             : number of mismatching vectors
//   first_err_valid/_vec  : index {cin,b,a} of the first mismatch
module cla_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 cin_out,
    input  logic [WIDTH-1:0]     sum_in,
    input  logic                 cout_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 first_err_valid,
    output logic [2*WIDTH:0]     first_err_vec
);

    localparam int VW = 2*WIDTH+1;
    localparam int EW = 2*WIDTH+2;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE-1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [VW-1:0] VEC_LAST = {VW{1'b1}};
    localparam logic [VW-1:0] VEC_ONE  = VW'(1);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  ref_sum;
    logic            mismatch;

    // The vector register is the output register: operands are its fields,
    // so they hold the last vector in DONE without extra state.
    assign a_out   = vec[WIDTH-1:0];
    assign b_out   = vec[2*WIDTH-1:WIDTH];
    assign cin_out = vec[VW-1];

    // Reference at WIDTH+1 bits so the carry-out is part of the comparison.
    assign ref_sum  = {1'b0, vec[WIDTH-1:0]}
                    + {1'b0, vec[2*WIDTH-1:WIDTH]}
                    + {{WIDTH{1'b0}}, vec[VW-1]};
    assign mismatch = ({cout_in, sum_in} != ref_sum);

    assign pass = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            vec             <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec             <= '0;
                        cnt             <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        done            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (!first_err_valid) begin
                            first_err_vec   <= vec;
                            first_err_valid <= 1'b1;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + VEC_ONE;
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sweep_checker.sv
// Purpose : self-checking bench for cla_sweep_checker with behavioural adder models (correct and stuck-at faults).
// Latency : checks done latency of 1024 cycles (SETTLE=1) and 2048 cycles (SETTLE=3) from start.
// Backpressure: none; exercises ignored starts mid-sweep and asynchronous reset mid-sweep.
module tb_cla_sweep_checker;

    localparam int W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            start3;
    logic [1:0]      fault;

    // SETTLE=1 instance, fault-injectable adder model
    logic [W-1:0]    a_out, b_out, sum_in;
    logic            cin_out, cout_in;
    logic            busy, done, pass, first_err_valid;
    logic [2*W+1:0]  err_count;
    logic [2*W:0]    first_err_vec;

    // SETTLE=3 instance, always-correct adder model
    logic [W-1:0]    a3, b3, sum3;
    logic            cin3, cout3;
    logic            busy3, done3, pass3, fev3;
    logic [2*W+1:0]  err3;
    logic [2*W:0]    fv3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_sweep_checker #(.WIDTH(W), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out), .cin_out(cin_out),
        .sum_in(sum_in), .cout_in(cout_in),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_vec(first_err_vec)
    );

    cla_sweep_checker #(.WIDTH(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_out(a3), .b_out(b3), .cin_out(cin3),
        .sum_in(sum3), .cout_in(cout3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_valid(fev3),
        .first_err_vec(fv3)
    );

    // fault: 0 = correct, 1 = cout stuck at 0, 2 = sum[0] stuck at 0
    always_comb begin
        logic [W:0] r;
        r       = {1'b0, a_out} + {1'b0, b_out} + {{W{1'b0}}, cin_out};
        sum_in  = r[W-1:0];
        cout_in = r[W];
        if (fault == 2'd1) cout_in   = 1'b0;
        if (fault == 2'd2) sum_in[0] = 1'b0;
    end

    always_comb begin
        logic [W:0] r3;
        r3    = {1'b0, a3} + {1'b0, b3} + {{W{1'b0}}, cin3};
        sum3  = r3[W-1:0];
        cout3 = r3[W];
    end

    typedef struct {
        int fault;
        int inj_a;      // run cycle of an ignored start pulse (-1 = none)
        int inj_b;
        int inj_rst;    // run cycle of a reset pulse (-1 = none)
        int exp_err;
        int exp_fev;
        int exp_fv;
        int exp_pass;
    } tv_t;

    tv_t tbl[5];
    tv_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"},    32'(a_out), 0);
        chk({tag, "_b"},    32'(b_out), 0);
        chk({tag, "_cin"},  32'(cin_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err"},  32'(err_count), 0);
        chk({tag, "_fev"},  32'(first_err_valid), 0);
        chk({tag, "_fv"},   32'(first_err_vec), 0);
    endtask

    task automatic run_case(input tv_t tv, input int idx);
        int  n;
        int  order_errs;
        bit  rst_fired;
        tv_t e;
        fault = 2'(tv.fault);
        sb.push_back(tv);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk($sformatf("c%0d_busy_rise", idx), 32'(busy), 1);
        chk($sformatf("c%0d_vec0", idx), 32'({cin_out, b_out, a_out}), 0);
        n = 0;
        order_errs = 0;
        rst_fired = 1'b0;
        while (!done && n < 3000) begin
            start = ((n + 1) == tv.inj_a) || ((n + 1) == tv.inj_b);
            tick;
            n++;
            start = 1'b0;
            if (n < 1024 && 32'({cin_out, b_out, a_out}) != 32'(n >> 1)) order_errs++;
            if (!rst_fired && n == tv.inj_rst) begin
                rst_fired = 1'b1;
                rst_n = 1'b0;
                #1;
                chk_all_zero($sformatf("c%0d_midrst", idx));
                #1;
                rst_n = 1'b1;
                tick;
                start = 1'b1;
                tick;
                start = 1'b0;
                chk($sformatf("c%0d_restart_vec0", idx), 32'({cin_out, b_out, a_out}), 0);
                chk($sformatf("c%0d_restart_busy", idx), 32'(busy), 1);
                n = 0;
                order_errs = 0;
            end
        end
        chk($sformatf("c%0d_done_latency", idx), 32'(n), 1024);
        chk($sformatf("c%0d_vec_order", idx), 32'(order_errs), 0);
        if (sb.size() == 0) begin
            chk($sformatf("c%0d_sb_empty", idx), 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("c%0d_err_count", idx), 32'(err_count), 32'(e.exp_err));
            chk($sformatf("c%0d_first_err_valid", idx), 32'(first_err_valid), 32'(e.exp_fev));
            chk($sformatf("c%0d_first_err_vec", idx), 32'(first_err_vec), 32'(e.exp_fv));
            chk($sformatf("c%0d_pass", idx), 32'(pass), 32'(e.exp_pass));
            chk($sformatf("c%0d_busy_low", idx), 32'(busy), 0);
            repeat (3) tick;
            chk($sformatf("c%0d_done_sticky", idx), 32'(done), 1);
            chk($sformatf("c%0d_hold_last_vec", idx), 32'({cin_out, b_out, a_out}), 32'h1FF);
            chk($sformatf("c%0d_err_hold", idx), 32'(err_count), 32'(e.exp_err));
        end
    endtask

    initial begin : main
        int n;
        int stab_errs;
        tbl[0] = '{fault: 0, inj_a: -1,  inj_b: -1,  inj_rst: -1,  exp_err: 0,   exp_fev: 0, exp_fv: 0,     exp_pass: 1};
        tbl[1] = '{fault: 1, inj_a: -1,  inj_b: -1,  inj_rst: -1,  exp_err: 256, exp_fev: 1, exp_fv: 'h01F, exp_pass: 0};
        tbl[2] = '{fault: 2, inj_a: -1,  inj_b: -1,  inj_rst: -1,  exp_err: 256, exp_fev: 1, exp_fv: 'h001, exp_pass: 0};
        tbl[3] = '{fault: 1, inj_a: 100, inj_b: 500, inj_rst: -1,  exp_err: 256, exp_fev: 1, exp_fv: 'h01F, exp_pass: 0};
        tbl[4] = '{fault: 2, inj_a: -1,  inj_b: -1,  inj_rst: 300, exp_err: 256, exp_fev: 1, exp_fv: 'h001, exp_pass: 0};

        fault  = 2'd0;
        start  = 1'b0;
        start3 = 1'b0;
        rst_n  = 1'b0;
        repeat (2) tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick;
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_case(tbl[i], i);
            repeat (2) tick;
        end

        // SETTLE=3: every vector held exactly 4 cycles, done after 2048
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        chk("s3_busy_rise", 32'(busy3), 1);
        chk("s3_vec0", 32'({cin3, b3, a3}), 0);
        n = 0;
        stab_errs = 0;
        while (!done3 && n < 5000) begin
            tick;
            n++;
            if (n < 2048 && 32'({cin3, b3, a3}) != 32'(n >> 2)) stab_errs++;
        end
        chk("s3_done_latency", 32'(n), 2048);
        chk("s3_vec_stable4", 32'(stab_errs), 0);
        chk("s3_pass", 32'(pass3), 1);
        chk("s3_err_count", 32'(err3), 0);
        chk("s3_fev", 32'(fev3), 0);
        chk("s3_fv", 32'(fv3), 0);
        chk("s3_busy_low", 32'(busy3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
